// File: rtl/hazard_stall_controller_if.sv
// Bundle of the ID/EX hazard signals between the pipeline and the
// hazard_stall_controller. The stall_cycles member exists only when
// HAZ_STALL_COUNT_EN is defined.
interface hazard_stall_controller_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_rt_used;
  logic        idex_memread;
  logic [4:0]  idex_rt;
  logic        id_muldiv_start;
  logic        id_reads_hilo;
  logic        id_branch_taken;
  logic        pc_write;
  logic        ifid_write;
  logic        idex_bubble;
  logic        ifid_flush;
  logic        muldiv_busy;
  logic        muldiv_done;
`ifdef HAZ_STALL_COUNT_EN
  logic [31:0] stall_cycles;
`endif

  // Pipeline side: presents the decoded ID/EX fields, consumes the controls.
  modport master (
    output id_rs, id_rt, id_rt_used, idex_memread, idex_rt,
           id_muldiv_start, id_reads_hilo, id_branch_taken,
    input  pc_write, ifid_write, idex_bubble, ifid_flush,
           muldiv_busy, muldiv_done
`ifdef HAZ_STALL_COUNT_EN
   ,input  stall_cycles
`endif
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, id_rt_used, idex_memread, idex_rt,
           id_muldiv_start, id_reads_hilo, id_branch_taken,
    output pc_write, ifid_write, idex_bubble, ifid_flush,
           muldiv_busy, muldiv_done
`ifdef HAZ_STALL_COUNT_EN
   ,output stall_cycles
`endif
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Hazard scheduler for the 5-stage MIPS core: load-use stalls, mult/div
// busy-window stalls for HI/LO consumers, and IF/ID flush on taken branches.
// Optional feature macro: HAZ_STALL_COUNT_EN adds a saturating stall counter.
module hazard_stall_controller #(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 6
) (
  input logic                       clk,
  input logic                       rst_n,
  hazard_stall_controller_if.slave  bus
);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LP_MD_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_md_cnt;
  logic [CNT_W-1:0] w_md_cnt_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_load_use;
  logic             w_md_hazard;
  logic             w_stall;

  // Hazard detection; rst_n gates the stall so a reset releases it at once.
  always_comb begin
    w_load_use  = bus.idex_memread && (bus.idex_rt != 5'd0) &&
                  ((bus.idex_rt == bus.id_rs) ||
                   (bus.id_rt_used && (bus.idex_rt == bus.id_rt)));
    w_md_hazard = (r_state == ST_MD_BUSY) &&
                  (bus.id_reads_hilo || bus.id_muldiv_start);
    w_stall     = rst_n && (w_load_use || w_md_hazard);
  end

  assign bus.pc_write    = ~w_stall;
  assign bus.ifid_write  = ~w_stall;
  assign bus.idex_bubble = w_stall;
  assign bus.ifid_flush  = rst_n & bus.id_branch_taken & ~w_stall;
  assign bus.muldiv_busy = (r_state == ST_MD_BUSY);
  assign bus.muldiv_done = r_done;

  // Next-state logic: accept a mult/div in RUN, count down the busy window.
  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    w_done_nxt   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.id_muldiv_start && !w_load_use) begin
          w_state_nxt  = ST_MD_BUSY;
          w_md_cnt_nxt = LP_MD_LOAD;
        end
      end
      ST_MD_BUSY: begin
        if (r_md_cnt == '0) begin
          w_state_nxt = ST_RUN;
          w_done_nxt  = 1'b1;
        end else begin
          w_md_cnt_nxt = r_md_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // State, counter and done-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_md_cnt <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
      r_done   <= w_done_nxt;
    end
  end

`ifdef HAZ_STALL_COUNT_EN
  logic [31:0] r_stall_cnt;

  // Count held-PC cycles, saturating at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Randomized self-checking bench for hazard_stall_controller with a
// remaining-cycles reference model of the mult/div unit.
module tb_hazard_stall_controller;

  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  // Reference model: cycles of busy window left, pending done pulse, stall count.
  int          m_busy_left;
  bit          m_done;
  int unsigned m_stall_cnt;

  hazard_stall_controller_if hif ();

  hazard_stall_controller #(
    .MULDIV_CYCLES (N),
    .CNT_W         (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic rt_used,
                       input logic memread, input logic [4:0] ex_rt,
                       input logic start, input logic hilo, input logic br);
    hif.id_rs           = rs;
    hif.id_rt           = rt;
    hif.id_rt_used      = rt_used;
    hif.idex_memread    = memread;
    hif.idex_rt         = ex_rt;
    hif.id_muldiv_start = start;
    hif.id_reads_hilo   = hilo;
    hif.id_branch_taken = br;
  endtask

  // Check one cycle at the falling edge, then advance the model on the rising edge.
  task automatic cycle();
    bit lu, busy, st, fl;
    @(negedge clk);
    lu   = hif.idex_memread && (hif.idex_rt != 0) &&
           ((hif.idex_rt == hif.id_rs) || (hif.id_rt_used && (hif.idex_rt == hif.id_rt)));
    busy = rst_n && (m_busy_left > 0);
    st   = rst_n && (lu || (busy && (hif.id_reads_hilo || hif.id_muldiv_start)));
    fl   = rst_n && hif.id_branch_taken && !st;
    check_eq("pc_write",    hif.pc_write,    !st);
    check_eq("ifid_write",  hif.ifid_write,  !st);
    check_eq("idex_bubble", hif.idex_bubble, st);
    check_eq("ifid_flush",  hif.ifid_flush,  fl);
    check_eq("muldiv_busy", hif.muldiv_busy, busy);
    check_eq("muldiv_done", hif.muldiv_done, m_done);
`ifdef HAZ_STALL_COUNT_EN
    check_eq("stall_cycles", hif.stall_cycles, m_stall_cnt);
`endif
    @(posedge clk);
    if (rst_n) begin
      if (st && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
      if (m_busy_left > 0) begin
        m_busy_left--;
        m_done = (m_busy_left == 0);
      end else begin
        m_done = 1'b0;
        if (hif.id_muldiv_start && !lu) m_busy_left = N;
      end
    end
    #1;
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from any clock edge.
  task automatic reset_pulse();
    #3 rst_n = 1'b0;
    #1;
    check_eq("rst_busy",  hif.muldiv_busy, 1'b0);
    check_eq("rst_pc",    hif.pc_write,    1'b1);
    check_eq("rst_bub",   hif.idex_bubble, 1'b0);
    check_eq("rst_flush", hif.ifid_flush,  1'b0);
    check_eq("rst_done",  hif.muldiv_done, 1'b0);
`ifdef HAZ_STALL_COUNT_EN
    check_eq("rst_cnt",   hif.stall_cycles, 32'd0);
`endif
    m_busy_left = 0;
    m_done      = 1'b0;
    m_stall_cnt = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    m_busy_left = 0;
    m_done      = 1'b0;
    m_stall_cnt = 0;
    rst_n       = 1'b0;
    // Hazardous inputs during reset must not stall.
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_pc",    hif.pc_write,    1'b1);
    check_eq("reset_ifid",  hif.ifid_write,  1'b1);
    check_eq("reset_bub",   hif.idex_bubble, 1'b0);
    check_eq("reset_flush", hif.ifid_flush,  1'b0);
    check_eq("reset_busy",  hif.muldiv_busy, 1'b0);
    check_eq("reset_done",  hif.muldiv_done, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Load-use on rs, then released.
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0); cycle();
    drive(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0); cycle();
    // $0 load never stalls; rt only matters when used.
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); cycle();
    drive(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0); cycle();
    drive(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0); cycle();
    // Branch during load-use is held off, then flushes.
    drive(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1); cycle();
    drive(5'd3, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1); cycle();

    // Stall count scenario from reset: 3 load-use + 4-cycle HI/LO wait.
    reset_pulse();
    repeat (3) begin
      drive(5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0); cycle();
    end
    drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); cycle();
    repeat (N) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      #1 check_eq("hilo_wait_busy", hif.muldiv_busy, 1'b1);
      check_eq("hilo_wait_pc", hif.pc_write, 1'b0);
      cycle();
    end
    check_eq("hilo_done", hif.muldiv_done, 1'b1);
    check_eq("hilo_done_pc", hif.pc_write, 1'b1);
`ifdef HAZ_STALL_COUNT_EN
    check_eq("stall_cnt_7", hif.stall_cycles, 32'd7);
`endif
    cycle();

    // Back-to-back mult/div: second start waits, accepted in the done cycle.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    repeat (N + 3) cycle();

    // Reset in the 2nd busy cycle.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); cycle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); cycle();
    reset_pulse();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle();

    // Randomized traffic over a small register set to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 63) == 0) reset_pulse();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
